prg_mmu_banked: RTL and testbench



---
 rtl/prg_mmu_banked.sv | 152 +++++++++++++++
 tb/tb_prg_mmu_banked.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_mmu_banked.sv
// Banked PRG mapper: splits CPU $8000-$FFFF into NUM_WIN windows, each mapped by an 8-bit bank register.
// Register writes are committed in the SYSCLK domain from a synchronised M2, behind a two-byte unlock key.
module prg_mmu_banked #(
    parameter int unsigned NUM_WIN   = 8,
    parameter int unsigned BANK_W    = 7,
    parameter logic [14:0] REG_BASE  = 15'h4020,
    parameter int unsigned FIXED_TOP = 1,
    parameter logic [7:0]  KEY0      = 8'hA5,
    parameter logic [7:0]  KEY1      = 8'h5A
) (
    input  logic              SYSCLK,
    input  logic              RESET,
    input  logic              M2,
    input  logic              nROMSEL,
    input  logic [14:0]       CPU_A,
    input  logic [7:0]        CPU_D,
    input  logic              CPU_RW,
    output logic [7:0]        CPU_DO,
    output logic              CPU_DOE,
    output logic [BANK_W-1:0] MMU_A,
    output logic              PRG_ROM_nCE,
    output logic              PRG_RAM_nCE,
    output logic              UNLOCKED
);

    localparam int unsigned      IDX_W    = $clog2(NUM_WIN);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_WIN - 1);
    localparam logic [14:0]      CTRL_OFF = 15'(NUM_WIN);

    localparam logic [1:0] ST_LOCKED   = 2'd0;
    localparam logic [1:0] ST_KEY_WAIT = 2'd1;
    localparam logic [1:0] ST_OPEN     = 2'd2;

    // Reset bank for window i: the top 32KB of ROM, modulo the bank space.
    function automatic logic [7:0] win_rst(input int unsigned i);
        int unsigned v;
        v = (32'd1 << BANK_W) - NUM_WIN + i;
        return 8'(v & ((32'd1 << BANK_W) - 32'd1));
    endfunction

    logic        m2_meta;
    logic        m2_s;
    logic        m2_s_d;
    logic [14:0] cap_a;
    logic [7:0]  cap_d;
    logic        cap_rw;
    logic        cap_romsel;
    logic        commit;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [7:0]  win_q [NUM_WIN];

    // M2 synchroniser, bus capture while M2 is high, one-cycle commit on M2 fall
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            m2_meta    <= 1'b0;
            m2_s       <= 1'b0;
            m2_s_d     <= 1'b0;
            cap_a      <= '0;
            cap_d      <= '0;
            cap_rw     <= 1'b0;
            cap_romsel <= 1'b0;
            commit     <= 1'b0;
        end else begin
            m2_meta <= M2;
            m2_s    <= m2_meta;
            m2_s_d  <= m2_s;
            if (m2_s) begin
                cap_a      <= CPU_A;
                cap_d      <= CPU_D;
                cap_rw     <= CPU_RW;
                cap_romsel <= nROMSEL;
            end
            commit <= m2_s_d && !m2_s && !cap_rw && cap_romsel;
        end
    end

    logic [14:0]      wr_off;
    logic             wr_win;
    logic             wr_ctrl;
    logic [IDX_W-1:0] wr_idx;
    logic             win_we;

    assign wr_off  = cap_a - REG_BASE;
    assign wr_win  = wr_off < CTRL_OFF;
    assign wr_ctrl = wr_off == CTRL_OFF;
    assign wr_idx  = wr_off[IDX_W-1:0];

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q <= ST_LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Unlock key sequence; a window write between the two key bytes aborts it
    always_comb begin
        state_d = state_q;
        if (commit) begin
            case (state_q)
                ST_LOCKED: begin
                    if (wr_ctrl && cap_d == KEY0) state_d = ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    if (wr_ctrl) state_d = (cap_d == KEY1) ? ST_OPEN : ST_LOCKED;
                    else if (wr_win) state_d = ST_LOCKED;
                end
                ST_OPEN: begin
                    if (wr_ctrl && cap_d == 8'h00) state_d = ST_LOCKED;
                end
                default: state_d = ST_LOCKED;
            endcase
        end
    end

    assign UNLOCKED = (state_q == ST_OPEN);
    assign win_we   = commit && (state_q == ST_OPEN) && wr_win &&
                      !(FIXED_TOP != 32'd0 && wr_idx == TOP_IDX);

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_WIN; i++) win_q[i] <= win_rst(i);
        end else if (win_we) begin
            win_q[wr_idx] <= cap_d;
        end
    end

    // Zero-latency ROM-space decode; the vector window is presented while nROMSEL is high
    logic [IDX_W-1:0] rom_idx;
    logic [7:0]       rom_win;

    assign rom_idx     = nROMSEL ? TOP_IDX : CPU_A[14 -: IDX_W];
    assign rom_win     = win_q[rom_idx];
    assign MMU_A       = rom_win[BANK_W-1:0];
    assign PRG_ROM_nCE = !(M2 && !nROMSEL && !rom_win[7]);
    assign PRG_RAM_nCE = !(M2 && !nROMSEL && rom_win[7]);

    logic [14:0] rd_off;

    assign rd_off  = CPU_A - REG_BASE;
    assign CPU_DOE = M2 && nROMSEL && CPU_RW && UNLOCKED && (rd_off <= CTRL_OFF);

    always_comb begin
        CPU_DO = 8'h00;
        if (CPU_DOE) begin
            if (rd_off == CTRL_OFF) CPU_DO = {7'b0, UNLOCKED};
            else                    CPU_DO = win_q[rd_off[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_prg_mmu_banked.sv
// Randomised bench for prg_mmu_banked: four parameterisations share one CPU bus and are compared
// every cycle against a window-table model, plus literal expectations from hand-worked cases.
module tb_prg_mmu_banked;

    logic        SYSCLK;
    logic        RESET;
    logic        M2;
    logic        nROMSEL;
    logic [14:0] CPU_A;
    logic [7:0]  CPU_D;
    logic        CPU_RW;

    logic [3:0][7:0] dout;
    logic [3:0]      doe;
    logic [3:0][6:0] mmu;
    logic [3:0]      rom_n;
    logic [3:0]      ram_n;
    logic [3:0]      unl;

    int checks;
    int failures;
    logic chk_en;

    int nw_a [4] = '{8, 8, 2, 16};
    int ft_a [4] = '{1, 0, 1, 1};
    logic [7:0] mwin [4][16];
    int mst [4];   // 0 locked, 1 first key seen, 2 open

    prg_mmu_banked #(.NUM_WIN(8), .BANK_W(7), .REG_BASE(15'h4020), .FIXED_TOP(1),
                     .KEY0(8'hA5), .KEY1(8'h5A)) u_d0 (
        .SYSCLK(SYSCLK), .RESET(RESET), .M2(M2), .nROMSEL(nROMSEL), .CPU_A(CPU_A),
        .CPU_D(CPU_D), .CPU_RW(CPU_RW), .CPU_DO(dout[0]), .CPU_DOE(doe[0]), .MMU_A(mmu[0]),
        .PRG_ROM_nCE(rom_n[0]), .PRG_RAM_nCE(ram_n[0]), .UNLOCKED(unl[0]));

    prg_mmu_banked #(.NUM_WIN(8), .BANK_W(7), .REG_BASE(15'h4020), .FIXED_TOP(0),
                     .KEY0(8'hA5), .KEY1(8'h5A)) u_d1 (
        .SYSCLK(SYSCLK), .RESET(RESET), .M2(M2), .nROMSEL(nROMSEL), .CPU_A(CPU_A),
        .CPU_D(CPU_D), .CPU_RW(CPU_RW), .CPU_DO(dout[1]), .CPU_DOE(doe[1]), .MMU_A(mmu[1]),
        .PRG_ROM_nCE(rom_n[1]), .PRG_RAM_nCE(ram_n[1]), .UNLOCKED(unl[1]));

    prg_mmu_banked #(.NUM_WIN(2), .BANK_W(7), .REG_BASE(15'h4020), .FIXED_TOP(1),
                     .KEY0(8'hA5), .KEY1(8'h5A)) u_d2 (
        .SYSCLK(SYSCLK), .RESET(RESET), .M2(M2), .nROMSEL(nROMSEL), .CPU_A(CPU_A),
        .CPU_D(CPU_D), .CPU_RW(CPU_RW), .CPU_DO(dout[2]), .CPU_DOE(doe[2]), .MMU_A(mmu[2]),
        .PRG_ROM_nCE(rom_n[2]), .PRG_RAM_nCE(ram_n[2]), .UNLOCKED(unl[2]));

    prg_mmu_banked #(.NUM_WIN(16), .BANK_W(7), .REG_BASE(15'h4020), .FIXED_TOP(1),
                     .KEY0(8'hA5), .KEY1(8'h5A)) u_d3 (
        .SYSCLK(SYSCLK), .RESET(RESET), .M2(M2), .nROMSEL(nROMSEL), .CPU_A(CPU_A),
        .CPU_D(CPU_D), .CPU_RW(CPU_RW), .CPU_DO(dout[3]), .CPU_DOE(doe[3]), .MMU_A(mmu[3]),
        .PRG_ROM_nCE(rom_n[3]), .PRG_RAM_nCE(ram_n[3]), .UNLOCKED(unl[3]));

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            mst[k] = 0;
            for (int i = 0; i < 16; i++) mwin[k][i] = 8'((128 - nw_a[k] + i) & 127);
        end
    endfunction

    // Effect of one committed CPU write at register-space address a
    function automatic void model_commit(input logic [14:0] a, input logic [7:0] d);
        int off;
        for (int k = 0; k < 4; k++) begin
            off = int'(a) - 'h4020;
            if (off == nw_a[k]) begin
                if (mst[k] == 0)      mst[k] = (d == 8'hA5) ? 1 : 0;
                else if (mst[k] == 1) mst[k] = (d == 8'h5A) ? 2 : 0;
                else if (d == 8'h00)  mst[k] = 0;
            end else if (off >= 0 && off < nw_a[k]) begin
                if (mst[k] == 1) mst[k] = 0;
                else if (mst[k] == 2 && !(ft_a[k] == 1 && off == nw_a[k] - 1)) mwin[k][off] = d;
            end
        end
    endfunction

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge SYSCLK) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                int nw;
                int idx;
                int off;
                logic [7:0] w;
                logic [7:0] t;
                logic [7:0] edo;
                logic eunl;
                logic edoe;
                nw   = nw_a[k];
                idx  = int'(CPU_A) / (32768 / nw);
                w    = mwin[k][idx];
                t    = mwin[k][nw - 1];
                eunl = (mst[k] == 2);
                off  = int'(CPU_A) - 'h4020;
                edoe = M2 && nROMSEL && CPU_RW && eunl && off >= 0 && off <= nw;
                edo  = 8'h00;
                if (edoe) edo = (off == nw) ? {7'b0, eunl} : mwin[k][off];
                chk("mmu", k, int'(mmu[k]), int'(nROMSEL ? t[6:0] : w[6:0]));
                chk("rom_nce", k, int'(rom_n[k]), int'(!(M2 && !nROMSEL && !w[7])));
                chk("ram_nce", k, int'(ram_n[k]), int'(!(M2 && !nROMSEL && w[7])));
                chk("unlocked", k, int'(unl[k]), int'(eunl));
                chk("doe", k, int'(doe[k]), int'(edoe));
                chk("do", k, int'(dout[k]), int'(edo));
            end
        end
    end

    task automatic go_idle();
        @(posedge SYSCLK);
        #1;
        M2 = 1'b0;
        CPU_RW = 1'b1;
        repeat (4) @(posedge SYSCLK);
        #1;
    endtask

    // Read cycle; returns at a falling edge with M2 still high so the caller can check outputs
    task automatic rd(input logic [14:0] a, input logic romsel);
        go_idle();
        CPU_A = a;
        nROMSEL = romsel;
        CPU_RW = 1'b1;
        M2 = 1'b1;
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK);
    endtask

    // Write cycle; the registers change on the 4th SYSCLK edge after M2 falls
    task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic romsel);
        go_idle();
        CPU_A = a;
        CPU_D = d;
        nROMSEL = romsel;
        CPU_RW = 1'b0;
        M2 = 1'b1;
        repeat (4) @(posedge SYSCLK);
        #1 M2 = 1'b0;
        repeat (4) @(posedge SYSCLK);
        #1;
        if (romsel) model_commit(a, d);
    endtask

    task automatic wr_reset_at_commit(input logic [14:0] a, input logic [7:0] d);
        go_idle();
        CPU_A = a;
        CPU_D = d;
        nROMSEL = 1'b1;
        CPU_RW = 1'b0;
        M2 = 1'b1;
        repeat (4) @(posedge SYSCLK);
        #1 M2 = 1'b0;
        repeat (3) @(posedge SYSCLK);
        #1 chk_en = 1'b0;
        RESET = 1'b1;
        @(posedge SYSCLK);
        #1 RESET = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic wr_reset_mid_m2(input logic [14:0] a, input logic [7:0] d);
        go_idle();
        CPU_A = a;
        CPU_D = d;
        nROMSEL = 1'b1;
        CPU_RW = 1'b0;
        M2 = 1'b1;
        repeat (4) @(posedge SYSCLK);
        #1 chk_en = 1'b0;
        M2 = 1'b0;
        RESET = 1'b1;
        repeat (2) @(posedge SYSCLK);
        #1 RESET = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (6) @(posedge SYSCLK);
    endtask

    task automatic unlock(input int k);
        wr(15'h4020 + 15'(nw_a[k]), 8'hA5, 1'b1);
        wr(15'h4020 + 15'(nw_a[k]), 8'h5A, 1'b1);
    endtask

    initial begin
        int r;
        logic [14:0] a;
        logic [7:0]  d;
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        RESET = 1'b1;
        M2 = 1'b0;
        nROMSEL = 1'b1;
        CPU_A = '0;
        CPU_D = '0;
        CPU_RW = 1'b1;
        model_reset();
        repeat (3) @(posedge SYSCLK);
        #1 RESET = 1'b0;
        chk_en = 1'b1;

        rd(15'h0000, 1'b0);
        chk("rst_mmu_8000", 0, int'(mmu[0]), 'h78);
        chk("rst_rom_nce", 0, int'(rom_n[0]), 0);
        chk("rst_ram_nce", 0, int'(ram_n[0]), 1);
        chk("rst_unlocked", 0, int'(unl[0]), 0);
        rd(15'h2000, 1'b0);
        chk("rst_mmu_a000", 0, int'(mmu[0]), 'h7A);
        rd(15'h6000, 1'b0);
        chk("rst_mmu_e000", 0, int'(mmu[0]), 'h7E);
        rd(15'h3FFF, 1'b0);
        chk("nw2_below_c000", 2, int'(mmu[2]), 'h7E);
        rd(15'h4000, 1'b0);
        chk("nw2_at_c000", 2, int'(mmu[2]), 'h7F);
        rd(15'h07FF, 1'b0);
        chk("nw16_below_8800", 3, int'(mmu[3]), 'h70);
        rd(15'h0800, 1'b0);
        chk("nw16_at_8800", 3, int'(mmu[3]), 'h71);

        wr(15'h4022, 8'h85, 1'b1);
        rd(15'h2000, 1'b0);
        chk("locked_win2", 0, int'(mmu[0]), 'h7A);
        rd(15'h4022, 1'b1);
        chk("locked_doe", 0, int'(doe[0]), 0);

        unlock(0);
        chk("unlock", 0, int'(unl[0]), 1);
        wr(15'h4022, 8'h85, 1'b1);
        rd(15'h2000, 1'b0);
        chk("open_win2_bank", 0, int'(mmu[0]), 'h05);
        chk("open_win2_ram", 0, int'(ram_n[0]), 0);
        chk("open_win2_rom", 0, int'(rom_n[0]), 1);
        rd(15'h4022, 1'b1);
        chk("rb_do", 0, int'(dout[0]), 'h85);
        chk("rb_doe", 0, int'(doe[0]), 1);
        rd(15'h4028, 1'b1);
        chk("rb_ctrl", 0, int'(dout[0]), 1);

        wr(15'h4028, 8'h00, 1'b1);
        chk("relock", 0, int'(unl[0]), 0);
        wr(15'h4028, 8'hA5, 1'b1);
        wr(15'h4021, 8'h11, 1'b1);
        wr(15'h4028, 8'h5A, 1'b1);
        chk("key_abort", 0, int'(unl[0]), 0);
        unlock(0);
        chk("unlock2", 0, int'(unl[0]), 1);
        wr(15'h4028, 8'h00, 1'b1);
        chk("lock_00", 0, int'(unl[0]), 0);

        unlock(0);
        wr(15'h4027, 8'h01, 1'b1);
        rd(15'h7C00, 1'b0);
        chk("fixed_top", 0, int'(mmu[0]), 'h7F);
        chk("free_top", 1, int'(mmu[1]), 'h01);

        wr_reset_at_commit(15'h4023, 8'h33);
        rd(15'h3000, 1'b0);
        chk("rst_commit_win3", 0, int'(mmu[0]), 'h7B);
        chk("rst_commit_lock", 0, int'(unl[0]), 0);
        rd(15'h7C00, 1'b0);
        chk("rst_commit_top", 1, int'(mmu[1]), 'h7F);

        unlock(0);
        wr_reset_mid_m2(15'h4023, 8'h44);
        rd(15'h3000, 1'b0);
        chk("rst_mid_m2_win3", 0, int'(mmu[0]), 'h7B);
        chk("rst_mid_m2_lock", 0, int'(unl[0]), 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 10);
            a = 15'h4020 + 15'($urandom_range(0, 18));
            if ($urandom_range(0, 7) == 0) a = 15'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 8'hA5;
                1:       d = 8'h5A;
                2:       d = 8'h00;
                default: d = 8'($urandom);
            endcase
            if (r < 5)       wr(a, d, 1'b1);
            else if (r < 7)  rd(15'($urandom), 1'b0);
            else if (r == 7) rd(a, 1'b1);
            else if (r == 8) wr(15'($urandom), d, 1'b0);
            else             unlock($urandom_range(0, 3));
        end

        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
